// File: rtl/pwm_fsm_gen.sv
// PWM generator paced by ticks derived from an upstream divided-clock level.
// A tick is the 0->1 transition of i_gen_clk seen in the i_clk domain.
// Each PWM cycle lasts act_per ticks. The output is high for the first
// act_duty ticks of the cycle. New duty and period values are staged first
// and move into the active registers only when a cycle starts.
module pwm_fsm_gen #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_gen_clk,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_duty,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_pwm,
  output logic             o_cycle_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           r_state;
  logic             r_gen_d;
  logic [WIDTH-1:0] r_stg_duty;
  logic [WIDTH-1:0] r_stg_per;
  logic [WIDTH-1:0] r_act_duty;
  logic [WIDTH-1:0] r_act_per;
  logic [WIDTH-1:0] r_cnt;

  logic             w_tick;
  logic             w_start_ok;
  logic             w_last;
  logic [WIDTH-1:0] w_cnt_inc;

  // i_gen_clk is only sampled as data; a tick is its rising level change.
  assign w_tick     = i_gen_clk & ~r_gen_d;
  // A cycle may begin only while enabled and with a non-zero staged period.
  assign w_start_ok = i_en && (r_stg_per != ZERO);
  // act_per is never zero while running, so act_per-1 cannot underflow here.
  assign w_last     = (r_cnt == (r_act_per - ONE));
  // cnt stays at or below act_per-1 <= 2^WIDTH-2, so cnt+1 never wraps.
  assign w_cnt_inc  = r_cnt + ONE;

  // Edge-detect history and staging registers written by the load strobe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets a cycle start pick up the old
  // staging values while a coincident load writes the new ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gen_d    <= 1'b0;
      r_stg_duty <= '0;
      r_stg_per  <= '0;
    end else begin
      r_gen_d <= i_gen_clk;
      if (i_load) begin
        r_stg_duty <= i_duty;
        r_stg_per  <= i_period;
      end
    end
  end

  // PWM state machine with its tick counter, active registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_act_duty   <= '0;
      r_act_per    <= '0;
      o_pwm        <= 1'b0;
      o_cycle_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      // Outputs follow the state register one clock later.
      o_pwm        <= (r_state == HIGH);
      o_busy       <= (r_state != IDLE);
      o_cycle_done <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (w_start_ok) begin
              r_act_duty <= r_stg_duty;
              r_act_per  <= r_stg_per;
              r_cnt      <= '0;
              r_state    <= (r_stg_duty != ZERO) ? HIGH : LOW;
            end
          end
          HIGH, LOW: begin
            if (w_last) begin
              // Cycle boundary: restart on this same tick, or retire to IDLE.
              o_cycle_done <= 1'b1;
              r_cnt        <= '0;
              if (w_start_ok) begin
                r_act_duty <= r_stg_duty;
                r_act_per  <= r_stg_per;
                r_state    <= (r_stg_duty != ZERO) ? HIGH : LOW;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_cnt <= w_cnt_inc;
              // duty >= period never matches here, so the output stays high.
              if ((r_state == HIGH) && (w_cnt_inc == r_act_duty)) begin
                r_state <= LOW;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_fsm_gen.sv
// Directed bench for pwm_fsm_gen. i_gen_clk is driven as a divide-by-4
// level, which gives one tick every 4 clocks. Outputs are logged on every
// falling clock edge. Each scenario then checks run lengths and pulse spacing
// in the log against hand-computed counts.
module tb_pwm_fsm_gen;

  localparam int W   = 8;
  localparam int LOG = 1024;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_gen_clk;
  logic         i_en;
  logic         i_load;
  logic [W-1:0] i_duty;
  logic [W-1:0] i_period;
  logic         o_pwm;
  logic         o_cycle_done;
  logic         o_busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Log layout: index 0 is o_pwm, 1 is o_cycle_done, 2 is o_busy.
  logic lg [0:2][0:LOG-1];
  int   ns;
  int   ph;
  bit   div_on;
  bit   load_req;
  logic [W-1:0] req_duty, req_per;

  pwm_fsm_gen #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_gen_clk    (i_gen_clk),
    .i_en         (i_en),
    .i_load       (i_load),
    .i_duty       (i_duty),
    .i_period     (i_period),
    .o_pwm        (o_pwm),
    .o_cycle_done (o_cycle_done),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // One clock: drive inputs just after the rising edge, log at the falling edge.
  task automatic run_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      if (div_on) begin
        ph        = (ph + 1) % 4;
        i_gen_clk = (ph >= 2);
      end else begin
        i_gen_clk = 1'b0;
      end
      if (load_req) begin
        i_load   = 1'b1;
        i_duty   = req_duty;
        i_period = req_per;
        load_req = 1'b0;
      end else begin
        i_load = 1'b0;
      end
      @(negedge i_clk);
      if (ns < LOG) begin
        lg[0][ns] = o_pwm;
        lg[1][ns] = o_cycle_done;
        lg[2][ns] = o_busy;
        ns++;
      end
    end
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    i_en      = 1'b0;
    i_load    = 1'b0;
    i_gen_clk = 1'b0;
    i_duty    = '0;
    i_period  = '0;
    load_req  = 1'b0;
    div_on    = 1'b0;
    ph        = 0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    ns    = 0;
  endtask

  task automatic request_load(input logic [W-1:0] d, input logic [W-1:0] p);
    req_duty = d;
    req_per  = p;
    load_req = 1'b1;
  endtask

  function automatic int run_len(input int sel, input int start, input logic v);
    int n = 0;
    while ((start + n < ns) && (lg[sel][start + n] === v)) n++;
    return n;
  endfunction

  function automatic int next_one(input int sel, input int start);
    for (int i = start; i < ns; i++) if (lg[sel][i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_ones(input int sel, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b && i < ns; i++) if (lg[sel][i] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic at(input int sel, input int idx);
    if (idx < 0 || idx >= ns) return 1'bx;
    return lg[sel][idx];
  endfunction

  // Step one clock at a time until a cycle-done pulse is logged. Returns its index or -1.
  task automatic run_until_done(input int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      run_clk(1);
      if (lg[1][ns-1] === 1'b1) begin
        idx = ns - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b0; i_load = 1'b0; i_gen_clk = 1'b0;
    i_duty = '0; i_period = '0;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_pwm !== 1'b0) begin n_mis++; $display("FAIL reset_pwm: got %b, required 0", o_pwm); end
    n_cmp++; if (o_busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    n_cmp++; if (o_cycle_done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b, required 0", o_cycle_done); end
  endtask

  // duty=3, period=8 with a tick every 4 clocks: 12 clocks high, 20 low, 32 per cycle.
  task automatic test_basic();
    int d0, d1, d2;
    do_reset();
    request_load(8'd3, 8'd8);
    i_en = 1'b1; div_on = 1'b1;
    run_clk(180);
    d0 = next_one(1, 0);
    n_cmp++; if (d0 < 0) begin n_mis++; $display("FAIL basic_first_done: got none, required a pulse"); end
    if (d0 >= 0) begin
      d1 = next_one(1, d0 + 1);
      d2 = (d1 >= 0) ? next_one(1, d1 + 1) : -1;
      n_cmp++; if (at(1, d0 + 1) !== 1'b0) begin n_mis++; $display("FAIL basic_done_width: got %b after pulse, required 0", at(1, d0 + 1)); end
      n_cmp++; if (at(0, d0) !== 1'b0) begin n_mis++; $display("FAIL basic_pwm_at_done: got %b, required 0", at(0, d0)); end
      n_cmp++; if (run_len(0, d0 + 1, 1'b1) != 12) begin n_mis++; $display("FAIL basic_high_len: got %0d, required 12", run_len(0, d0 + 1, 1'b1)); end
      n_cmp++; if (run_len(0, d0 + 13, 1'b0) != 20) begin n_mis++; $display("FAIL basic_low_len: got %0d, required 20", run_len(0, d0 + 13, 1'b0)); end
      n_cmp++; if (d1 - d0 != 32) begin n_mis++; $display("FAIL basic_done_spacing1: got %0d, required 32", d1 - d0); end
      n_cmp++; if (d2 - d1 != 32) begin n_mis++; $display("FAIL basic_done_spacing2: got %0d, required 32", d2 - d1); end
      n_cmp++; if (run_len(0, d1 + 1, 1'b1) != 12) begin n_mis++; $display("FAIL basic_high_len2: got %0d, required 12", run_len(0, d1 + 1, 1'b1)); end
      n_cmp++; if (count_ones(2, d0, d0 + 64) != 65) begin n_mis++; $display("FAIL basic_busy: got %0d busy clocks, required 65", count_ones(2, d0, d0 + 64)); end
    end
  endtask

  // duty=0 keeps the output low; duty=9 > period=5 keeps it high. Both pulse done every 20 clocks.
  task automatic test_duty_extremes();
    int d0, d1;
    do_reset();
    request_load(8'd0, 8'd5);
    i_en = 1'b1; div_on = 1'b1;
    run_clk(120);
    d0 = next_one(1, 0);
    d1 = (d0 >= 0) ? next_one(1, d0 + 1) : -1;
    n_cmp++; if (d0 < 0 || d1 - d0 != 20) begin n_mis++; $display("FAIL zero_duty_spacing: got %0d, required 20", d1 - d0); end
    n_cmp++; if (count_ones(0, 0, ns - 1) != 0) begin n_mis++; $display("FAIL zero_duty_pwm: got %0d high clocks, required 0", count_ones(0, 0, ns - 1)); end
    n_cmp++; if (d0 < 0 || count_ones(2, d0, ns - 1) != ns - d0) begin n_mis++; $display("FAIL zero_duty_busy: got %0d busy, required %0d", count_ones(2, d0, ns - 1), ns - d0); end

    do_reset();
    request_load(8'd9, 8'd5);
    i_en = 1'b1; div_on = 1'b1;
    run_clk(120);
    d0 = next_one(1, 0);
    d1 = (d0 >= 0) ? next_one(1, d0 + 1) : -1;
    n_cmp++; if (d0 < 0 || d1 - d0 != 20) begin n_mis++; $display("FAIL full_duty_spacing: got %0d, required 20", d1 - d0); end
    n_cmp++; if (d0 < 0 || count_ones(0, d0, ns - 1) != ns - d0) begin n_mis++; $display("FAIL full_duty_pwm: got %0d high, required %0d", count_ones(0, d0, ns - 1), ns - d0); end
  endtask

  // duty=2, period=4 running. Loading duty=3 mid-cycle leaves the current cycle
  // at 8 high clocks. The next cycle has 12 high clocks, and the boundary stays 16 clocks out.
  task automatic test_reload();
    int d0;
    do_reset();
    request_load(8'd2, 8'd4);
    i_en = 1'b1; div_on = 1'b1;
    run_until_done(100, d0);
    n_cmp++; if (d0 < 0) begin n_mis++; $display("FAIL reload_first_done: got none, required a pulse"); end
    if (d0 >= 0) begin
      run_clk(5);
      request_load(8'd3, 8'd4);
      run_clk(40);
      n_cmp++; if (run_len(0, d0 + 1, 1'b1) != 8) begin n_mis++; $display("FAIL reload_cur_high: got %0d, required 8", run_len(0, d0 + 1, 1'b1)); end
      n_cmp++; if (at(1, d0 + 16) !== 1'b1 || count_ones(1, d0 + 1, d0 + 15) != 0) begin n_mis++; $display("FAIL reload_boundary: got done=%b extra=%0d, required 1 and 0", at(1, d0 + 16), count_ones(1, d0 + 1, d0 + 15)); end
      n_cmp++; if (run_len(0, d0 + 17, 1'b1) != 12) begin n_mis++; $display("FAIL reload_next_high: got %0d, required 12", run_len(0, d0 + 17, 1'b1)); end
    end
  endtask

  // period=6: i_en drops after the first tick. The cycle still ends 24 clocks
  // after its start, with one more done pulse, and then the FSM stays idle.
  task automatic test_disable();
    int d0;
    do_reset();
    request_load(8'd2, 8'd6);
    i_en = 1'b1; div_on = 1'b1;
    run_until_done(100, d0);
    n_cmp++; if (d0 < 0) begin n_mis++; $display("FAIL disable_first_done: got none, required a pulse"); end
    if (d0 >= 0) begin
      run_clk(4);
      i_en = 1'b0;
      run_clk(70);
      n_cmp++; if (at(1, d0 + 24) !== 1'b1) begin n_mis++; $display("FAIL disable_boundary: got %b, required 1", at(1, d0 + 24)); end
      n_cmp++; if (count_ones(1, d0 + 1, ns - 1) != 1) begin n_mis++; $display("FAIL disable_done_count: got %0d, required 1", count_ones(1, d0 + 1, ns - 1)); end
      n_cmp++; if (at(2, d0 + 24) !== 1'b1 || at(2, d0 + 25) !== 1'b0) begin n_mis++; $display("FAIL disable_busy_edge: got %b%b, required 10", at(2, d0 + 24), at(2, d0 + 25)); end
      n_cmp++; if (count_ones(2, d0 + 25, ns - 1) + count_ones(0, d0 + 25, ns - 1) != 0) begin n_mis++; $display("FAIL disable_idle: got %0d active clocks, required 0", count_ones(2, d0 + 25, ns - 1) + count_ones(0, d0 + 25, ns - 1)); end
    end
  endtask

  // A zero period never starts. A non-zero period then starts on the next tick.
  task automatic test_zero_period();
    int k, b;
    do_reset();
    request_load(8'd2, 8'd0);
    i_en = 1'b1; div_on = 1'b1;
    run_clk(40);
    n_cmp++; if (count_ones(2, 0, ns - 1) + count_ones(1, 0, ns - 1) != 0) begin n_mis++; $display("FAIL zero_period_idle: got %0d active clocks, required 0", count_ones(2, 0, ns - 1) + count_ones(1, 0, ns - 1)); end
    k = ns;
    request_load(8'd2, 8'd4);
    run_clk(20);
    b = next_one(2, k);
    n_cmp++; if (b < 0 || b - k < 3 || b - k > 6) begin n_mis++; $display("FAIL zero_period_start: got busy %0d clocks after load drive, required 3..6", b - k); end
  endtask

  // A sub-cycle reset pulse while HIGH clears the outputs at once and also clears the staging values.
  task automatic test_async_reset();
    int k, b;
    do_reset();
    request_load(8'd3, 8'd8);
    i_en = 1'b1; div_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      run_clk(1);
      if (o_pwm === 1'b1) break;
    end
    n_cmp++; if (o_pwm !== 1'b1) begin n_mis++; $display("FAIL async_pre_high: got %b, required 1", o_pwm); end
    #1 i_rst = 1'b1;
    #1;
    n_cmp++; if (o_pwm !== 1'b0) begin n_mis++; $display("FAIL async_pwm: got %b, required 0", o_pwm); end
    n_cmp++; if (o_busy !== 1'b0) begin n_mis++; $display("FAIL async_busy: got %b, required 0", o_busy); end
    #1 i_rst = 1'b0;
    ns = 0;
    run_clk(60);
    n_cmp++; if (count_ones(0, 0, ns - 1) + count_ones(1, 0, ns - 1) + count_ones(2, 0, ns - 1) != 0) begin n_mis++; $display("FAIL async_quiet: got %0d active samples, required 0", count_ones(0, 0, ns - 1) + count_ones(1, 0, ns - 1) + count_ones(2, 0, ns - 1)); end
    k = ns;
    request_load(8'd3, 8'd8);
    run_clk(20);
    b = next_one(2, k);
    n_cmp++; if (b < 0 || b - k < 3 || b - k > 6) begin n_mis++; $display("FAIL async_restart: got busy %0d clocks after load drive, required 3..6", b - k); end
  endtask

  initial begin
    ns = 0; ph = 0; div_on = 1'b0; load_req = 1'b0;
    req_duty = '0; req_per = '0;
    test_reset();
    test_basic();
    test_duty_extremes();
    test_reload();
    test_disable();
    test_zero_period();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pwm_fsm_gen.md
PWM_FSM_GEN -- requirements
Module: pwm_fsm_gen

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of the duty, period and tick counter.
REQ-002 i_clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 i_gen_clk  input  1  SHALL be the divided-clock level from the upstream clock divider, synchronous to i_clk, and SHALL be used only as data, never as a clock.
REQ-005 i_en  input  1  SHALL be the PWM run enable.
REQ-006 i_load  input  1  SHALL be a one-cycle strobe that captures i_duty and i_period into the staging registers.
REQ-007 i_duty  input  WIDTH  SHALL be the high time, in ticks, of a PWM cycle.
REQ-008 i_period  input  WIDTH  SHALL be the length, in ticks, of a PWM cycle.
REQ-009 o_pwm  output  1  SHALL be the registered PWM waveform.
REQ-010 o_cycle_done  output  1  SHALL be a one-clock pulse at each PWM cycle boundary.
REQ-011 o_busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-012 A tick SHALL be a one-clock strobe asserted when i_gen_clk is 1 and its one-cycle-delayed register is 0 (rising-edge detect, 0 to 1 only).
REQ-013 i_load=1 SHALL write i_duty and i_period into the staging registers stg_duty and stg_per at that edge, with no other effect.
REQ-014 Active registers act_duty and act_per SHALL load from the staging registers only when a cycle starts (REQ-016/REQ-018), using the staging values held before that same edge; a load coincident with a cycle start SHALL take effect at the next boundary.
REQ-015 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-016 IDLE: on a tick with i_en=1 and stg_per!=0, the FSM SHALL load the active registers, clear cnt to 0, and go to HIGH if stg_duty!=0, else to LOW; in every other case it SHALL remain in IDLE.
REQ-017 HIGH/LOW, tick with cnt != act_per-1: cnt SHALL increment; in HIGH, if cnt+1 == act_duty, the FSM SHALL go to LOW; in LOW, it SHALL stay in LOW.
REQ-018 HIGH/LOW, tick with cnt == act_per-1 (cycle boundary): o_cycle_done SHALL pulse for one clock, and the FSM SHALL go to IDLE if i_en=0 or stg_per=0; otherwise it SHALL restart per REQ-016 without skipping a tick.
REQ-019 If act_duty >= act_per, the output SHALL stay high for the whole cycle; if act_duty=0, it SHALL stay low for the whole cycle.
REQ-020 o_pwm SHALL be 1 only in HIGH, so it changes on the clock edge after the state changes; o_busy SHALL follow the state register the same way.
REQ-021 Deasserting i_en mid-cycle SHALL let the current cycle complete and then enter IDLE at the boundary.
REQ-022 Without ticks, state, cnt and outputs SHALL hold, except staging writes.
REQ-023 cnt SHALL never exceed act_per-1 and SHALL never wrap through 2^WIDTH.

Reset
REQ-024 While i_rst=1, state SHALL be IDLE and cnt, stg_duty, stg_per, act_duty, act_per, the edge-detect register, o_pwm, o_cycle_done and o_busy SHALL all be 0.
REQ-025 i_rst asserted mid-cycle SHALL force REQ-024 values immediately, without waiting for a clock edge; after release, operation SHALL begin only from IDLE on a new tick.

Verification
REQ-026 i_gen_clk = div4 (tick every 4 clocks), load duty=3, period=8, i_en=1 -> o_pwm high for 12 clocks then low for 20 clocks, repeating; o_cycle_done pulses every 32 clocks.
REQ-027 duty=0, period=5 -> o_pwm constantly 0, o_busy=1, o_cycle_done every 5 ticks; duty=9, period=5 -> o_pwm constantly 1 while running.
REQ-028 Running duty=2, period=4; load duty=3 mid-cycle -> the current cycle keeps 2 high ticks, the next cycle has 3, and the boundary pulse is not delayed.
REQ-029 i_en dropped at tick 1 of period=6 -> 5 more ticks complete, o_cycle_done pulses once, then IDLE with o_busy=0 and o_pwm=0.
REQ-030 period=0 loaded with i_en=1 -> the FSM stays in IDLE; loading period=4 -> it starts on the next tick.
REQ-031 i_rst pulsed for less than one clock period while in HIGH -> o_pwm=0, o_busy=0 and staging cleared immediately; no output activity until a new load with i_en=1 and a tick.
